// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR+R) between ifetch (port 0) and data (port 1).
// Latency: ack same cycle as req, arvalid one cycle later; R beats pass through combinationally.
// Backpressure: requester rready stalls the bus directly; ARB_RID_CHECK_EN enables sticky rid-mismatch err.
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req,
  output logic [1:0]              ack,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [15:0]             len,
  output logic [1:0]              rvalid,
  input  logic [1:0]              rready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state;
  logic       gnt;
  logic       last_gnt;
  logic       winner;
  logic       in_data;
  logic       rid_bad;
  logic       burst_done;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ~last_gnt;
  end

  assign ack = (reset_n && (state == IDLE) && (req != 2'b00)) ?
               (winner ? 2'b10 : 2'b01) : 2'b00;

  assign in_data = (state == DATA);

`ifdef ARB_RID_CHECK_EN
  assign rid_bad = in_data && m_axi_rvalid && (m_axi_rid != m_axi_arid);
`else
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;
  assign rid_bad    = 1'b0;
`endif

  // Mismatching beats are drained from the bus but hidden from the requester.
  assign m_axi_rready = in_data && (rid_bad || rready[gnt]);
  assign rvalid       = (in_data && m_axi_rvalid && !rid_bad) ?
                        (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign r_data       = m_axi_rdata;
  assign r_resp       = m_axi_rresp;
  assign r_last       = m_axi_rlast;

  assign burst_done = in_data && m_axi_rvalid && m_axi_rready && m_axi_rlast && !rid_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      last_gnt      <= 1'b1;
      m_axi_arvalid <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arburst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt           <= winner;
            m_axi_arid    <= ID_WIDTH'(winner);
            m_axi_araddr  <= winner ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
            m_axi_arlen   <= winner ? len[15:8] : len[7:0];
            m_axi_arburst <= winner ? 2'b01 : 2'b10;
            m_axi_arvalid <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (burst_done) begin
            last_gnt <= gnt;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_RID_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err <= 1'b0;
    else if (rid_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: the bench plays both requesters and the AXI slave,
// predicting grants, AR fields and R routing from a transaction-level round-robin model.
module tb_axi_rd_arbiter;
  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [1:0]      ack;
  logic [2*AW-1:0] addr = '0;
  logic [15:0]     len = '0;
  logic [1:0]      rvalid;
  logic [1:0]      rready = 2'b00;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic [IDW-1:0]  m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready = 1'b0;
  logic [IDW-1:0]  m_axi_rid = '0;
  logic [DW-1:0]   m_axi_rdata = '0;
  logic [1:0]      m_axi_rresp = 2'b00;
  logic            m_axi_rlast = 1'b0;
  logic            m_axi_rvalid = 1'b0;
  logic            m_axi_rready;
  logic            err;

  int vectors     = 0;
  int miscompares = 0;
  bit model_last  = 1'b1;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .addr(addr), .len(len),
    .rvalid(rvalid), .rready(rready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err(err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full request/AR/R transaction. The AXI slave side is driven by the bench.
  task automatic burst(input logic [1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1,
                       input int ar_stall, input int rv_pct, input int rr_pct);
    bit             w;
    logic [AW-1:0]  ea;
    logic [7:0]     el;
    logic [1:0]     exp_sel;
    int             beats_left;
    int             cycles;
    @(posedge clk); #1;
    req = r; addr = {a1, a0}; len = {l1, l0};
    m_axi_rvalid = 1'($urandom_range(0, 1)); rready = 2'b11; m_axi_rlast = 1'b1;
    @(negedge clk);
    if (r == 2'b00) begin
      check("ack_noreq", ack, 2'b00);
      check("rready_idle", m_axi_rready, 1'b0);
    end else begin
      w       = (r == 2'b11) ? ~model_last : r[1];
      ea      = w ? a1 : a0;
      el      = w ? l1 : l0;
      exp_sel = w ? 2'b10 : 2'b01;
      check("ack", ack, exp_sel);
      check("rready_idle", m_axi_rready, 1'b0);
      check("rvalid_idle", rvalid, 2'b00);
      for (int k = 0; k <= ar_stall; k++) begin
        @(posedge clk); #1;
        req = 2'($urandom); addr = {rnd64(), rnd64()}; len = 16'($urandom);
        m_axi_arready = (k == ar_stall);
        m_axi_rvalid  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("arvalid", m_axi_arvalid, 1'b1);
        check("araddr", m_axi_araddr, ea);
        check("arlen", m_axi_arlen, el);
        check("arburst", m_axi_arburst, w ? 2'b01 : 2'b10);
        check("arid", m_axi_arid, IDW'(w));
        check("ack_addr", ack, 2'b00);
        check("rready_addr", m_axi_rready, 1'b0);
        check("rvalid_addr", rvalid, 2'b00);
      end
      beats_left = int'(el) + 1;
      cycles     = 0;
      while (beats_left > 0 && cycles < 400) begin
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        req           = 2'($urandom);
        m_axi_rvalid  = (int'($urandom_range(0, 99)) < rv_pct);
        m_axi_rdata   = rnd64();
        m_axi_rresp   = 2'($urandom);
        m_axi_rlast   = (beats_left == 1);
        m_axi_rid     = IDW'(w);
        rready[0]     = (int'($urandom_range(0, 99)) < rr_pct);
        rready[1]     = (int'($urandom_range(0, 99)) < rr_pct);
        @(negedge clk);
        check("rvalid", rvalid, m_axi_rvalid ? exp_sel : 2'b00);
        check("m_rready", m_axi_rready, rready[w]);
        check("r_data", r_data, m_axi_rdata);
        check("r_resp", r_resp, m_axi_rresp);
        check("r_last", r_last, m_axi_rlast);
        check("arvalid_data", m_axi_arvalid, 1'b0);
        check("ack_data", ack, 2'b00);
        if (m_axi_rvalid && rready[w]) beats_left--;
        cycles++;
      end
      if (beats_left > 0) check("burst_timeout", 1'b1, 1'b0);
      model_last = w;
      // Back in IDLE: a stray beat must not be accepted.
      @(posedge clk); #1;
      req = 2'b00; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; rready = 2'b11;
      @(negedge clk);
      check("rready_after", m_axi_rready, 1'b0);
      check("rvalid_after", rvalid, 2'b00);
    end
    #1 m_axi_rvalid = 1'b0;
  endtask

  initial begin
    req = 2'b11;
    #2;
    check("rst_ack", ack, 2'b00);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_araddr", m_axi_araddr, '0);
    check("rst_arlen", m_axi_arlen, 8'h00);
    @(posedge clk); #1;
    req = 2'b00; reset_n = 1'b1;

    // Simultaneous requests out of reset alternate starting with ifetch.
    for (int i = 0; i < 3; i++)
      burst(2'b11, rnd64(), rnd64(), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 0, 100, 100);
    burst(2'b01, 64'h1000, rnd64(), 8'd7, 8'd3, 0, 100, 100);
    burst(2'b10, rnd64(), 64'h2000_0040, 8'd2, 8'd4, 5, 100, 100);
    burst(2'b10, rnd64(), rnd64(), 8'd1, 8'd6, 1, 100, 40);
    burst(2'b01, rnd64(), rnd64(), 8'd0, 8'd0, 0, 100, 100);
    for (int i = 0; i < 40; i++)
      burst(2'($urandom), rnd64(), rnd64(), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 60, 60);

    // Reset asserted during beat 3 of an 8-beat ifetch burst.
    @(posedge clk); #1;
    req = 2'b01; addr = {rnd64(), 64'h3000}; len = 16'h0007;
    @(posedge clk); #1;
    req = 2'b00; m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; m_axi_rid = '0; rready = 2'b11;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rvalid_pre", rvalid, 2'b01);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_rready", m_axi_rready, 1'b0);
    check("mid_rst_rvalid", rvalid, 2'b00);
    check("mid_rst_arvalid", m_axi_arvalid, 1'b0);
    model_last = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    m_axi_rvalid = 1'b0; reset_n = 1'b1;
    burst(2'b11, rnd64(), rnd64(), 8'd1, 8'd1, 0, 100, 100);

`ifdef ARB_RID_CHECK_EN
    @(posedge clk); #1;
    req = 2'b01; addr = {rnd64(), 64'h4000}; len = 16'h0000;
    @(posedge clk); #1;
    req = 2'b00; m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = IDW'(1); rready = 2'b01;
    @(negedge clk);
    check("rid_bad_rvalid", rvalid, 2'b00);
    check("rid_bad_rready", m_axi_rready, 1'b1);
    @(posedge clk); #1;
    m_axi_rid = '0;
    @(negedge clk);
    check("rid_err", err, 1'b1);
    check("rid_still_data", rvalid, 2'b01);
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    @(negedge clk);
    check("rid_err_sticky", err, 1'b1);
    check("rid_done_idle", m_axi_rready, 1'b0);
    model_last = 1'b0;
`else
    check("err_tied", err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR + R) of `top` between two requesters: instruction fetch (port 0) and data load (port 1).
- Round-robin arbitration, one burst outstanding at a time.
- R beats are routed back to the granted requester, and stalls propagate back to the bus.
- Sits between the fetch/LSU front ends and the `m_axi_ar*`/`m_axi_r*` pins of `top`.

Parameters:
ID_WIDTH, 13, width of `m_axi_arid`/`m_axi_rid`
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, R data width

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk
req  in  2  per-requester burst request; bit0 = ifetch, bit1 = data
ack  out  2  one-cycle pulse: the request is latched; requester may drop or change `req`/`addr`/`len`
addr  in  2*ADDR_WIDTH  request addresses; [ADDR_WIDTH-1:0] = ifetch
len  in  16  AXI arlen per requester; [7:0] = ifetch
rvalid  out  2  per-requester R beat valid
rready  in  2  per-requester R beat ready
r_data  out  DATA_WIDTH  broadcast beat data
r_resp  out  2  broadcast beat response
r_last  out  1  broadcast last-beat flag
m_axi_arid  out  ID_WIDTH  0 for ifetch, 1 for data
m_axi_araddr  out  ADDR_WIDTH  registered address
m_axi_arlen  out  8  registered length
m_axi_arburst  out  2  2'b10 (WRAP) for ifetch, 2'b01 (INCR) for data
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  ID_WIDTH  R id
m_axi_rdata  in  DATA_WIDTH  R data
m_axi_rresp  in  2  R response
m_axi_rlast  in  1  R last
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
err  out  1  sticky rid-mismatch flag (optional feature)

Behaviour:
- **Reset.** Asynchronous reset (`reset_n` = 0) forces state IDLE, `last_gnt` = 1 (so ifetch wins first), and all outputs to 0: `ack`, `rvalid`, `m_axi_arvalid`, `m_axi_rready`, `err`, and all registered AR fields. Reset mid-burst abandons the burst; no beats are forwarded afterwards.
- **States: IDLE, ADDR, DATA.**
- **IDLE.**
  - If `req` is nonzero, pick a winner. When both are set, the winner is the requester ≠ `last_gnt`; otherwise the single requester wins.
  - `ack[winner]` = 1 combinationally in the same cycle.
  - At the clock edge, latch `addr`/`len`/id/burst of the winner into the AR registers, set `gnt` = winner, and go to ADDR.
  - If `req` = 0, stay in IDLE with `ack` = 0.
- **ADDR.**
  - `m_axi_arvalid` = 1, registered; it rises the cycle after `ack`.
  - AR fields hold stable while `m_axi_arvalid` = 1 and `m_axi_arready` = 0; `arvalid` is never withdrawn.
  - On `m_axi_arvalid` & `m_axi_arready`, go to DATA; `m_axi_arvalid` = 0 next cycle.
  - `req` is ignored in ADDR and DATA; no `ack` is issued.
- **DATA.**
  - Combinational pass-through: `rvalid[gnt]` = `m_axi_rvalid`, the other bit = 0; `m_axi_rready` = `rready[gnt]`.
  - `r_data`/`r_resp`/`r_last` mirror the `m_axi_r*` inputs.
  - No added latency and no buffering; a requester stall back-pressures the bus.
  - On `m_axi_rvalid` & `m_axi_rready` & `m_axi_rlast`: go to IDLE and set `last_gnt` = `gnt`. The next arbitration can occur in the following cycle.
- **Outside DATA:** `m_axi_rready` = 0 and `rvalid` = 0; stray R beats are not accepted.
- **Burst length.** `len` = 0 gives a single-beat burst; completion is on its `rlast`.
- **Beat count.** The arbiter does not count beats; `m_axi_rlast` alone ends the burst.
- **Throughput.** Minimum turnaround per burst is IDLE, then ADDR (≥1 cycle), then DATA (≥1 beat); at best a new AR issues every 3 cycles.
- **rresp.** SLVERR/DECERR responses are forwarded unchanged; the arbiter takes no action on them.

Optional Feature:
- Macro: ARB_RID_CHECK_EN.
- **Defined:**
  - In DATA, a beat whose `m_axi_rid` ≠ the issued id sets `err`. `err` is sticky until reset.
  - The mismatching beat is consumed (`m_axi_rready` = 1) and not forwarded (`rvalid` = 0).
  - A mismatching beat with `rlast` = 1 does not end the burst.
- **Undefined:** `m_axi_rid` is ignored and `err` is tied to 0.

Test Plan:
- **Single ifetch.** `req` = 01, `addr0` = 0x1000, `len0` = 7 → `ack` = 01 in the same cycle. Next cycle `arvalid` = 1, `araddr` = 0x1000, `arlen` = 7, `arburst` = 10, `arid` = 0. 8 beats appear on `rvalid[0]`; return to IDLE after the `rlast` beat.
- **Simultaneous requests, out of reset.** `req` = 11 → ifetch granted first; data granted on the next IDLE with `arburst` = 01, `arid` = 1. With `req` held at 11, the next grant goes to ifetch (strict alternation).
- **AR stall.** `m_axi_arready` held at 0 for 5 cycles → `arvalid` and `araddr` stay stable for all 5 cycles; handshake completes on cycle 6.
- **Requester R stall.** `rready[1]` = 0 while `m_axi_rvalid` = 1 → `m_axi_rready` = 0 and the beat is held. After release, `r_data` matches each bus beat in order; `rvalid[0]` stays 0 throughout.
- **Reset mid-burst.** `reset_n` low during beat 3 of 8 → `m_axi_rready`, `rvalid`, and `arvalid` go to 0 without waiting for a clock edge. After release, state is IDLE and `req` = 11 grants ifetch.
- **Rid mismatch (ARB_RID_CHECK_EN).** `rid` = 1 during an ifetch burst → `err` = 1 and stays 1; the beat is not forwarded on `rvalid[0]`.
